// File: rtl/fetch_queue_stage.sv
// Instruction fetch front end: one outstanding imem read, results queued with PC+4 for decode.
// Latency: zero-wait memory gives id_valid one cycle after the request; decode backpressure stalls fetch when the queue is full.

module fq_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_push_vld,
  input  logic [W-1:0]             i_push_dat,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push_vld && !reset && !i_clr) begin
      r_mem[r_wptr] <= i_push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push_vld) r_wptr <= r_wptr + AW'(1);
      if (i_pop)      r_rptr <= r_rptr + AW'(1);
      case ({i_push_vld, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_dat = r_mem[r_rptr];
  assign o_count    = r_count;
endmodule

module fetch_queue_stage #(
  parameter logic [31:0] ENTRY = 32'h0000_0080,
  parameter int          DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        INT,
  input  logic [31:0] entryPoint,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_ins,
  output logic [31:0] id_pcp4
);
  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0] ENTRY_PC = ENTRY & ~32'h3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pcp4;
  } fq_entry_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_drain_addr;
  logic [31:0] w_drain_nxt;

  logic          w_req;
  logic          w_hs;
  logic          w_flush;
  logic [31:0]   w_target;
  logic [31:0]   w_pc_plus4;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  fq_entry_t     w_head;
  fq_entry_t     w_push_dat;

  assign w_flush    = INT | redirect;
  assign w_target   = (INT ? entryPoint : redirect_pc) & ~32'h3;
  assign w_pc_plus4 = r_pc + 32'd4;

  // A raised request is never withdrawn; only a fresh one waits for queue room.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_IDLE:          w_req = (w_count < FULL_CNT);
      S_WAIT, S_DRAIN: w_req = 1'b1;
      default:         w_req = 1'b0;
    endcase
    if (reset) w_req = 1'b0;
  end

  assign w_hs      = w_req & imem_ack;
  assign imem_req  = w_req;
  assign imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drain_nxt = r_drain_addr;
    if (w_flush) begin
      w_pc_nxt = w_target;
      if (w_req && !imem_ack) begin
        w_state_nxt = S_DRAIN;
        w_drain_nxt = imem_addr;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (imem_ack) w_pc_nxt    = w_pc_plus4;
            else          w_state_nxt = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = S_IDLE;
          end
        end
        S_DRAIN: begin
          if (imem_ack) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= ENTRY_PC;
      r_drain_addr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drain_addr <= w_drain_nxt;
    end
  end

  // Drained data belongs to a squashed path and is dropped.
  assign w_push          = w_hs & (r_state != S_DRAIN) & ~w_flush;
  assign w_pop           = id_valid & id_ready & ~w_flush;
  assign w_push_dat.ins  = imem_rdata;
  assign w_push_dat.pcp4 = w_pc_plus4;

  fq_fifo #(
    .W     ($bits(fq_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_flush),
    .i_push_vld (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_count)
  );

  assign id_valid = (w_count != '0);
  assign id_ins   = id_valid ? w_head.ins  : '0;
  assign id_pcp4  = id_valid ? w_head.pcp4 : '0;
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: memory model returns word = address,
// expected entries are queued on each completed fetch and compared at the decode head.
module tb_fetch_queue_stage;
  localparam logic [31:0] ENTRY = 32'h0000_0080;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        INT = 1'b0;
  logic [31:0] entryPoint = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_ins;
  logic [31:0] id_pcp4;

  always #5 clk = ~clk;

  fetch_queue_stage #(.ENTRY(ENTRY), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .INT         (INT),
    .entryPoint  (entryPoint),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_ins      (id_ins),
    .id_pcp4     (id_pcp4)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pcp4;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc = ENTRY;
  logic [31:0] held_addr = '0;
  bit          outst = 1'b0;
  bit          squash = 1'b0;
  bit          force_ack = 1'b0;
  int          wait_cnt = 0;
  int          lat = 0;
  bit          d_reset = 1'b1;
  bit          d_redir = 1'b0;
  bit          d_int = 1'b0;
  bit          d_rdy = 1'b1;
  logic [31:0] d_rpc = '0;
  logic [31:0] d_ep = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic        req_s;
    logic        ack_s;
    logic [31:0] addr_s;
    bit          flush;
    exp_t        e;
    @(negedge clk);
    reset       = d_reset;
    redirect    = d_redir;
    INT         = d_int;
    redirect_pc = d_rpc;
    entryPoint  = d_ep;
    id_ready    = d_rdy;
    #1;
    imem_ack   = force_ack | (imem_req & (wait_cnt >= lat));
    imem_rdata = imem_ack ? imem_addr : 32'hDEAD_BEEF;
    #1;
    req_s  = imem_req;
    ack_s  = imem_ack;
    addr_s = imem_addr;

    chk("id_valid", {31'd0, id_valid}, {31'd0, (sb_q.size() != 0)});
    if (sb_q.size() != 0) begin
      chk("id_ins", id_ins, sb_q[0].ins);
      chk("id_pcp4", id_pcp4, sb_q[0].pcp4);
    end else begin
      chk("empty_ins", id_ins, 32'd0);
      chk("empty_pcp4", id_pcp4, 32'd0);
    end
    if (d_reset) begin
      chk("req_in_reset", {31'd0, req_s}, 32'd0);
    end else if (outst) begin
      chk("req_hold", {31'd0, req_s}, 32'd1);
      chk("addr_hold", addr_s, held_addr);
    end else begin
      chk("req", {31'd0, req_s}, {31'd0, (sb_q.size() < DEPTH)});
      if (req_s) chk("addr", addr_s, exp_pc);
    end

    if (d_reset) begin
      sb_q.delete();
      exp_pc = ENTRY;
      outst  = 1'b0;
      squash = 1'b0;
    end else begin
      flush = d_int | d_redir;
      if (!flush && sb_q.size() != 0 && d_rdy) void'(sb_q.pop_front());
      if (req_s && ack_s) begin
        if (squash) begin
          squash = 1'b0;
        end else if (!flush) begin
          e.ins  = addr_s;
          e.pcp4 = addr_s + 32'd4;
          sb_q.push_back(e);
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (flush) begin
        sb_q.delete();
        exp_pc = (d_int ? d_ep : d_rpc) & ~32'h3;
        squash = req_s && !ack_s;
      end
      outst     = req_s && !ack_s;
      held_addr = addr_s;
    end
    @(posedge clk);
    wait_cnt = (req_s && !ack_s && !d_reset) ? wait_cnt + 1 : 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Streaming with zero-wait memory
    d_reset = 1'b1; run(2);
    d_reset = 1'b0; lat = 0; d_rdy = 1'b1; run(6);

    // Decode backpressure fills the queue, then releases
    d_reset = 1'b1; run(1);
    d_reset = 1'b0; d_rdy = 1'b0; run(5);
    d_rdy = 1'b1; run(4);

    // Slow memory
    d_reset = 1'b1; run(1);
    d_reset = 1'b0; lat = 0; run(1);
    lat = 3; run(10);
    lat = 0;

    // Redirect while a fetch is pending, then drain
    d_reset = 1'b1; run(1);
    d_reset = 1'b0; run(2);
    lat = 99; run(2);
    d_redir = 1'b1; d_rpc = 32'h0000_0203; run(1);
    d_redir = 1'b0; run(2);
    lat = 0; run(4);

    // Interrupt beats redirect on the same edge
    d_int = 1'b1; d_redir = 1'b1; d_ep = 32'h0000_0180; d_rpc = 32'h0000_0300; run(1);
    d_int = 1'b0; d_redir = 1'b0; run(4);

    // Reset in the middle of a wait, with a late ack during reset
    d_rdy = 1'b0; lat = 0; run(1);
    lat = 99; run(2);
    d_reset = 1'b1; force_ack = 1'b1; run(1);
    force_ack = 1'b0; run(1);
    d_reset = 1'b0; lat = 0; d_rdy = 1'b1; run(4);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      d_rdy   = ($urandom_range(0, 3) != 0);
      d_redir = ($urandom_range(0, 19) == 0);
      d_int   = ($urandom_range(0, 39) == 0);
      d_rpc   = $urandom;
      d_ep    = $urandom;
      d_reset = ($urandom_range(0, 149) == 0);
      if (!outst) lat = $urandom_range(0, 3);
      cycle();
    end
    d_reset = 1'b0; d_redir = 1'b0; d_int = 1'b0; d_rdy = 1'b1; lat = 0;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
